// File: rtl/alu_reservation_station_pkg.sv
// Shared core types for the ALU reservation station.
// Tags, opcodes and the per-entry field bundle.
package alu_reservation_station_pkg;

  localparam int RS_DEPTH = 4;
  localparam int TAG_W = 5;

  typedef logic [TAG_W-1:0] RS_tag_type;

  localparam RS_tag_type INVALID = '1;

  typedef enum logic [6:0] {
    OP_NONE = 7'b0000000,
    LUI     = 7'b0110111,
    AUIPC   = 7'b0010111,
    JAL     = 7'b1101111,
    JALR    = 7'b1100111,
    BRANCH  = 7'b1100011,
    LOAD    = 7'b0000011,
    STORE   = 7'b0100011,
    OP_IMM  = 7'b0010011,
    OP      = 7'b0110011,
    SYSTEM  = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic [3:0]  alu_fun;
    opcode_t     opcode;
    RS_tag_type  rd_tag;
    logic [31:0] v1;
    logic [31:0] v2;
  } rs_fields_t;

  function automatic logic src_hit(
    input RS_tag_type q,
    input RS_tag_type cdb
  );
    return (cdb != INVALID) && (q == cdb);
  endfunction

endpackage

// File: rtl/alu_reservation_station_rs_entry.sv
// One reservation-station entry: fields, operand
// capture on dispatch (with CDB bypass) and CDB snoop.
module rs_entry
  import alu_reservation_station_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alloc,
  input  logic        sel,
  input  logic        retire,
  input  rs_fields_t  disp,
  input  RS_tag_type  disp_q1,
  input  RS_tag_type  disp_q2,
  input  logic [31:0] cdb_val,
  input  RS_tag_type  cdb_tag,
  output logic        busy,
  output logic        issued,
  output logic        ready,
  output rs_fields_t  fields
);

  rs_fields_t f;
  RS_tag_type q1, q2;
  logic       v1_ok, v2_ok;

  assign fields = f;
  assign ready  = busy & v1_ok & v2_ok;

  // Entry state: allocate, snoop the CDB, issue, retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      issued <= 1'b0;
      v1_ok  <= 1'b0;
      v2_ok  <= 1'b0;
      q1     <= INVALID;
      q2     <= INVALID;
      f      <= '0;
    end else if (alloc) begin
      busy   <= 1'b1;
      issued <= 1'b0;
      f      <= disp;
      q1     <= disp_q1;
      q2     <= disp_q2;
      if (disp_q1 == INVALID) begin
        v1_ok <= 1'b1;
      end else if (src_hit(disp_q1, cdb_tag)) begin
        f.v1  <= cdb_val;
        v1_ok <= 1'b1;
      end else begin
        v1_ok <= 1'b0;
      end
      if (disp_q2 == INVALID) begin
        v2_ok <= 1'b1;
      end else if (src_hit(disp_q2, cdb_tag)) begin
        f.v2  <= cdb_val;
        v2_ok <= 1'b1;
      end else begin
        v2_ok <= 1'b0;
      end
    end else if (busy) begin
      if (retire) begin
        busy   <= 1'b0;
        issued <= 1'b0;
        v1_ok  <= 1'b0;
        v2_ok  <= 1'b0;
      end else begin
        if (sel) begin
          issued <= 1'b1;
        end
        if (!v1_ok && src_hit(q1, cdb_tag)) begin
          f.v1  <= cdb_val;
          v1_ok <= 1'b1;
        end
        if (!v2_ok && src_hit(q2, cdb_tag)) begin
          f.v2  <= cdb_val;
          v2_ok <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: DEPTH entries, lowest-free
// allocation, lowest-ready single-issue select, ALU mux.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [3:0]               disp_alu_fun,
  input  opcode_t                  disp_opcode,
  input  RS_tag_type               disp_rd_tag,
  input  logic [31:0]              disp_v1,
  input  logic [31:0]              disp_v2,
  input  RS_tag_type               disp_q1,
  input  RS_tag_type               disp_q2,
  input  logic [31:0]              CDB_val,
  input  RS_tag_type               CDB_tag,
  output logic [31:0]              V1,
  output logic [31:0]              V2,
  output logic                     V1_valid,
  output logic                     V2_valid,
  output logic [3:0]               alu_fun,
  output RS_tag_type               rd_tag,
  output opcode_t                  OPCODE,
  input  logic                     alu_done,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] busy, issued, ready;
  logic [DEPTH-1:0] alloc, sel, retire;
  rs_fields_t       ent [DEPTH];
  rs_fields_t       disp;

  assign disp = '{
    alu_fun: disp_alu_fun,
    opcode:  disp_opcode,
    rd_tag:  disp_rd_tag,
    v1:      disp_v1,
    v2:      disp_v2
  };

  assign disp_ready = ~&busy;
  assign retire     = issued & {DEPTH{alu_done}};

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    rs_entry u_ent (
      .clk     (CLK),
      .rst_n   (RST_N),
      .alloc   (alloc[i]),
      .sel     (sel[i]),
      .retire  (retire[i]),
      .disp    (disp),
      .disp_q1 (disp_q1),
      .disp_q2 (disp_q2),
      .cdb_val (CDB_val),
      .cdb_tag (CDB_tag),
      .busy    (busy[i]),
      .issued  (issued[i]),
      .ready   (ready[i]),
      .fields  (ent[i])
    );
  end

  // Lowest free entry takes the dispatch; lowest
  // ready entry issues only when nothing is in flight.
  always_comb begin
    logic got_free, got_sel;
    alloc    = '0;
    sel      = '0;
    got_free = 1'b0;
    got_sel  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !got_free) begin
        alloc[i] = disp_valid;
        got_free = 1'b1;
      end
      if (ready[i] && !got_sel && !(|issued)) begin
        sel[i]  = 1'b1;
        got_sel = 1'b1;
      end
    end
  end

  // Drive the issued entry to the ALU, idle otherwise.
  always_comb begin
    V1       = '0;
    V2       = '0;
    V1_valid = 1'b0;
    V2_valid = 1'b0;
    alu_fun  = '0;
    rd_tag   = INVALID;
    OPCODE   = OP_NONE;
    for (int i = 0; i < DEPTH; i++) begin
      if (issued[i]) begin
        V1       = ent[i].v1;
        V2       = ent[i].v2;
        V1_valid = 1'b1;
        V2_valid = 1'b1;
        alu_fun  = ent[i].alu_fun;
        rd_tag   = ent[i].rd_tag;
        OPCODE   = ent[i].opcode;
      end
    end
  end

  // Busy-entry count.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(busy[i]);
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station:
// vector table for single-entry flows plus sequences.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        disp_valid;
  logic        disp_ready;
  logic [3:0]  disp_alu_fun;
  opcode_t     disp_opcode;
  RS_tag_type  disp_rd_tag;
  logic [31:0] disp_v1, disp_v2;
  RS_tag_type  disp_q1, disp_q2;
  logic [31:0] CDB_val;
  RS_tag_type  CDB_tag;
  logic [31:0] V1, V2;
  logic        V1_valid, V2_valid;
  logic [3:0]  alu_fun;
  RS_tag_type  rd_tag;
  opcode_t     OPCODE;
  logic        alu_done;
  logic [2:0]  occupancy;

  int n_pass = 0;
  int n_total = 0;

  alu_reservation_station dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_alu_fun (disp_alu_fun),
    .disp_opcode  (disp_opcode),
    .disp_rd_tag  (disp_rd_tag),
    .disp_v1      (disp_v1),
    .disp_v2      (disp_v2),
    .disp_q1      (disp_q1),
    .disp_q2      (disp_q2),
    .CDB_val      (CDB_val),
    .CDB_tag      (CDB_tag),
    .V1           (V1),
    .V2           (V2),
    .V1_valid     (V1_valid),
    .V2_valid     (V2_valid),
    .alu_fun      (alu_fun),
    .rd_tag       (rd_tag),
    .OPCODE       (OPCODE),
    .alu_done     (alu_done),
    .occupancy    (occupancy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  fun;
    opcode_t     op;
    RS_tag_type  rd;
    logic [31:0] v1, v2;
    RS_tag_type  q1, q2;
    RS_tag_type  ctag;
    logic [31:0] cval;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t vec [4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    CDB_tag    = INVALID;
    CDB_val    = '0;
    alu_done   = 1'b0;
  endtask

  task automatic disp(input logic [3:0] fun,
                      input opcode_t op,
                      input RS_tag_type rd,
                      input logic [31:0] v1,
                      input logic [31:0] v2,
                      input RS_tag_type q1,
                      input RS_tag_type q2);
    disp_valid   = 1'b1;
    disp_alu_fun = fun;
    disp_opcode  = op;
    disp_rd_tag  = rd;
    disp_v1      = v1;
    disp_v2      = v2;
    disp_q1      = q1;
    disp_q2      = q2;
  endtask

  task automatic retire_then(input RS_tag_type nxt);
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    chk("gap_idle", 32'(rd_tag), 32'(INVALID));
    step();
    chk("next_issue", 32'(rd_tag), 32'(nxt));
  endtask

  task automatic retire_last();
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    chk("drain_occ", 32'(occupancy), 0);
    chk("drain_tag", 32'(rd_tag), 32'(INVALID));
  endtask

  initial begin
    vec[0] = '{4'h0, OP, 5'd4, 32'd5, 32'd7,
               INVALID, INVALID, INVALID, 32'd0,
               32'd5, 32'd7};
    vec[1] = '{4'h8, OP, 5'd5, 32'hDEAD, 32'd3,
               5'd2, INVALID, 5'd2, 32'd42,
               32'd42, 32'd3};
    vec[2] = '{4'h7, OP_IMM, 5'd6, 32'h1, 32'h2,
               5'd10, 5'd10, 5'd10, 32'hCAFEF00D,
               32'hCAFEF00D, 32'hCAFEF00D};
    vec[3] = '{4'h1, OP, 5'd0, 32'hFFFFFFFF, 32'd0,
               INVALID, INVALID, 5'd12, 32'h55,
               32'hFFFFFFFF, 32'd0};

    RST_N = 1'b0;
    idle();
    disp(4'h0, OP_NONE, 5'd0, '0, '0, INVALID, INVALID);
    disp_valid = 1'b0;
    #12;
    chk("rst_ready", 32'(disp_ready), 1);
    chk("rst_v1v", 32'(V1_valid), 0);
    chk("rst_tag", 32'(rd_tag), 32'(INVALID));
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_v1", V1, 0);
    chk("rst_op", 32'(OPCODE), 0);
    #3 RST_N = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      disp(vec[i].fun, vec[i].op, vec[i].rd,
           vec[i].v1, vec[i].v2, vec[i].q1, vec[i].q2);
      CDB_tag = vec[i].ctag;
      CDB_val = vec[i].cval;
      step();
      idle();
      chk("v_occ1", 32'(occupancy), 1);
      chk("v_notyet", 32'(V1_valid), 0);
      step();
      chk("v_V1", V1, vec[i].e1);
      chk("v_V2", V2, vec[i].e2);
      chk("v_valid", 32'({V1_valid, V2_valid}), 3);
      chk("v_tag", 32'(rd_tag), 32'(vec[i].rd));
      chk("v_fun", 32'(alu_fun), 32'(vec[i].fun));
      chk("v_op", 32'(OPCODE), 32'(vec[i].op));
      retire_last();
    end

    // snoop wakeup
    disp(4'h0, OP, 5'd11, 32'h0, 32'd9, 5'd3, INVALID);
    step();
    idle();
    step();
    chk("sn_wait", 32'(V1_valid), 0);
    CDB_tag = 5'd3;
    CDB_val = 32'h1234;
    step();
    idle();
    chk("sn_capt", 32'(V1_valid), 0);
    step();
    chk("sn_V1", V1, 32'h1234);
    chk("sn_V2", V2, 32'd9);
    chk("sn_tag", 32'(rd_tag), 11);
    retire_last();

    // fill and free
    for (int t = 1; t <= 4; t++) begin
      disp(4'h0, OP, RS_tag_type'(t), 32'(t), 0,
           INVALID, INVALID);
      step();
    end
    chk("full_rdy", 32'(disp_ready), 0);
    chk("full_occ", 32'(occupancy), 4);
    chk("full_tag", 32'(rd_tag), 1);
    disp(4'h0, OP, 5'd5, 32'd5, 0, INVALID, INVALID);
    step();
    idle();
    chk("ovf_occ", 32'(occupancy), 4);
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    chk("free_rdy", 32'(disp_ready), 1);
    chk("free_occ", 32'(occupancy), 3);
    chk("free_gap", 32'(rd_tag), 32'(INVALID));
    disp(4'h0, OP, 5'd6, 32'h66, 0, INVALID, INVALID);
    step();
    idle();
    chk("refill_occ", 32'(occupancy), 4);
    chk("sel_t2", 32'(rd_tag), 2);
    retire_then(5'd6);
    chk("slot0_V1", V1, 32'h66);
    retire_then(5'd3);
    retire_then(5'd4);
    retire_last();

    // stall
    disp(4'h2, OP, 5'd7, 32'h70, 32'h71, INVALID, INVALID);
    step();
    disp(4'h3, OP, 5'd8, 32'h80, 32'h81, INVALID, INVALID);
    step();
    idle();
    for (int c = 0; c < 10; c++) begin
      chk("stall_tag", 32'(rd_tag), 7);
      chk("stall_V1", V1, 32'h70);
      step();
    end
    retire_then(5'd8);
    chk("stall_V2", V2, 32'h81);
    retire_last();

    // async reset mid-issue
    disp(4'h0, OP, 5'd9, 32'h9, 32'h9, INVALID, INVALID);
    step();
    disp(4'h0, OP, 5'd13, 32'h9, 32'h9, INVALID, INVALID);
    step();
    idle();
    chk("pre_tag", 32'(rd_tag), 9);
    #2 RST_N = 1'b0;
    #1;
    chk("ar_tag", 32'(rd_tag), 32'(INVALID));
    chk("ar_occ", 32'(occupancy), 0);
    chk("ar_V1", V1, 0);
    chk("ar_rdy", 32'(disp_ready), 1);
    #1 RST_N = 1'b1;
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    chk("late_occ", 32'(occupancy), 0);
    chk("late_tag", 32'(rd_tag), 32'(INVALID));
    step();
    chk("late_tag2", 32'(rd_tag), 32'(INVALID));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
